// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the RV32I decode stage.
//   - opcode values and one-hot opcode-class encodings (out_alu_op)
//   - branch-op, memory-width and operand-source encodings
//   - funct7 values, including the M-extension group
//   - decode_bundle_t: the complete control bundle handed to execute
//   - immediate extraction helpers for the I/S/B/U/J formats
package decode_pkg;

   localparam int DEFAULT_XLEN = 32;
   localparam int CLS_W        = 7;
   localparam int SEL_W        = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // One-hot opcode class; bit order R, I_op, I_ld, S, B, U, J from LSB.
   localparam logic [CLS_W-1:0] CLS_NONE = 7'b0000000;
   localparam logic [CLS_W-1:0] CLS_R    = 7'b0000001;
   localparam logic [CLS_W-1:0] CLS_I_OP = 7'b0000010;
   localparam logic [CLS_W-1:0] CLS_I_LD = 7'b0000100;
   localparam logic [CLS_W-1:0] CLS_S    = 7'b0001000;
   localparam logic [CLS_W-1:0] CLS_B    = 7'b0010000;
   localparam logic [CLS_W-1:0] CLS_U    = 7'b0100000;
   localparam logic [CLS_W-1:0] CLS_J    = 7'b1000000;

   localparam logic [SEL_W-1:0] BR_NEVER   = 4'b0000;
   localparam logic [SEL_W-1:0] BR_ZERO    = 4'b0101;
   localparam logic [SEL_W-1:0] BR_NONZERO = 4'b1010;
   localparam logic [SEL_W-1:0] BR_ALWAYS  = 4'b1111;

   localparam logic [SEL_W-1:0] MEM_WORD = 4'b0000;
   localparam logic [SEL_W-1:0] MEM_HALF = 4'b0101;
   localparam logic [SEL_W-1:0] MEM_BYTE = 4'b1010;

   localparam logic [SEL_W-1:0] SRC_REG   = 4'b0000;
   localparam logic [SEL_W-1:0] SRC1_PC   = 4'b0101;
   localparam logic [SEL_W-1:0] SRC1_ZERO = 4'b1010;
   localparam logic [SEL_W-1:0] SRC2_IMM  = 4'b0101;
   localparam logic [SEL_W-1:0] SRC2_FOUR = 4'b1010;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic             rs1_read;
      logic             rs2_read;
      logic             rd_write;
      logic [31:0]      imm;
      logic [CLS_W-1:0] alu_op;
      logic [2:0]       funct3;
      logic             sub_sra;
      logic [SEL_W-1:0] src1;
      logic [SEL_W-1:0] src2;
      logic             mem_read;
      logic             mem_write;
      logic [SEL_W-1:0] mem_width;
      logic             mem_zext;
      logic [SEL_W-1:0] branch_op;
      logic             jalr;
      logic             muldiv;
      logic             illegal;
   } decode_bundle_t;

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      return {instr[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle of the decode stage.
//   master: the surrounding pipeline (drives in_*, flush_in, out_ready)
//   slave : decode_stage (drives in_ready and all out_* fields)
interface decode_if
   import decode_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
);
   logic             in_valid;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             in_ready;
   logic             flush_in;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic             out_rs1_read;
   logic             out_rs2_read;
   logic             out_rd_write;
   logic [XLEN-1:0]  out_imm;
   logic [CLS_W-1:0] out_alu_op;
   logic [2:0]       out_funct3;
   logic             out_sub_sra;
   logic [SEL_W-1:0] out_src1;
   logic [SEL_W-1:0] out_src2;
   logic             out_mem_read;
   logic             out_mem_write;
   logic [SEL_W-1:0] out_mem_width;
   logic             out_mem_zext;
   logic [SEL_W-1:0] out_branch_op;
   logic             out_jalr;
   logic             out_muldiv;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush_in, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
             out_rs1_read, out_rs2_read, out_rd_write, out_imm, out_alu_op,
             out_funct3, out_sub_sra, out_src1, out_src2, out_mem_read,
             out_mem_write, out_mem_width, out_mem_zext, out_branch_op,
             out_jalr, out_muldiv, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush_in, out_ready,
      output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
             out_rs1_read, out_rs2_read, out_rd_write, out_imm, out_alu_op,
             out_funct3, out_sub_sra, out_src1, out_src2, out_mem_read,
             out_mem_write, out_mem_width, out_mem_zext, out_branch_op,
             out_jalr, out_muldiv, out_illegal
   );
endinterface

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I(+M) instruction decoder.
//   instr : 32-bit instruction word
//   dec   : decoded control bundle (decode_bundle_t)
// Recognised opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
// Anything else, a bad funct3/funct7, or the M group with ENABLE_M=0 is
// flagged illegal and made side-effect free.
module decode_comb
   import decode_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0]    instr,
   output decode_bundle_t dec
);
   logic [6:0]     opcode;
   logic [2:0]     f3;
   logic [6:0]     f7;
   decode_bundle_t raw;
   logic           bad;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   // Per-opcode control decode plus legality of funct3/funct7.
   always_comb begin
      raw        = '0;
      bad        = 1'b0;
      raw.funct3 = f3;
      case (opcode)
         OPC_LUI: begin
            raw.alu_op = CLS_U;   raw.rd_write = 1'b1; raw.imm = imm_u(instr);
            raw.src1 = SRC1_ZERO; raw.src2 = SRC2_IMM;
         end
         OPC_AUIPC: begin
            raw.alu_op = CLS_U;   raw.rd_write = 1'b1; raw.imm = imm_u(instr);
            raw.src1 = SRC1_PC;   raw.src2 = SRC2_IMM;
         end
         OPC_JAL: begin
            raw.alu_op = CLS_J;   raw.rd_write = 1'b1; raw.imm = imm_j(instr);
            raw.src1 = SRC1_PC;   raw.src2 = SRC2_FOUR; raw.branch_op = BR_ALWAYS;
         end
         OPC_JALR: begin
            raw.alu_op = CLS_J;   raw.rd_write = 1'b1; raw.imm = imm_i(instr);
            raw.rs1_read = 1'b1;  raw.jalr = 1'b1;
            raw.src1 = SRC1_PC;   raw.src2 = SRC2_FOUR; raw.branch_op = BR_ALWAYS;
            bad = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            raw.alu_op = CLS_B;   raw.imm = imm_b(instr); raw.sub_sra = 1'b1;
            raw.rs1_read = 1'b1;  raw.rs2_read = 1'b1;
            // Equal / greater-equal test the compare result for zero.
            case (f3)
               3'b000, 3'b101, 3'b111: raw.branch_op = BR_ZERO;
               3'b001, 3'b100, 3'b110: raw.branch_op = BR_NONZERO;
               default:                bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            raw.alu_op = CLS_I_LD; raw.imm = imm_i(instr); raw.src2 = SRC2_IMM;
            raw.rs1_read = 1'b1;   raw.rd_write = 1'b1;  raw.mem_read = 1'b1;
            case (f3)
               3'b000:  raw.mem_width = MEM_BYTE;
               3'b001:  raw.mem_width = MEM_HALF;
               3'b010:  raw.mem_width = MEM_WORD;
               3'b100:  begin raw.mem_width = MEM_BYTE; raw.mem_zext = 1'b1; end
               3'b101:  begin raw.mem_width = MEM_HALF; raw.mem_zext = 1'b1; end
               default: bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            raw.alu_op = CLS_S;   raw.imm = imm_s(instr); raw.src2 = SRC2_IMM;
            raw.rs1_read = 1'b1;  raw.rs2_read = 1'b1;  raw.mem_write = 1'b1;
            case (f3)
               3'b000:  raw.mem_width = MEM_BYTE;
               3'b001:  raw.mem_width = MEM_HALF;
               3'b010:  raw.mem_width = MEM_WORD;
               default: bad = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            raw.alu_op = CLS_I_OP; raw.imm = imm_i(instr); raw.src2 = SRC2_IMM;
            raw.rs1_read = 1'b1;   raw.rd_write = 1'b1;
            // Only the shift-immediates constrain the upper bits.
            case (f3)
               3'b001:  bad = (f7 != F7_BASE);
               3'b101:  begin
                  bad         = (f7 != F7_BASE) && (f7 != F7_ALT);
                  raw.sub_sra = instr[30];
               end
               default: bad = 1'b0;
            endcase
         end
         OPC_OP: begin
            raw.alu_op = CLS_R;   raw.rd_write = 1'b1;
            raw.rs1_read = 1'b1;  raw.rs2_read = 1'b1;
            if (f7 == F7_MULDIV) begin
               raw.muldiv = 1'b1;
               bad        = (ENABLE_M == 1'b0);
            end else if (f7 == F7_ALT) begin
               raw.sub_sra = 1'b1;
               bad         = (f3 != 3'b000) && (f3 != 3'b101);
            end else begin
               bad = (f7 != F7_BASE);
            end
         end
         default: bad = 1'b1;
      endcase
   end

   // Illegal squash, x0 write suppression and masking of unused indices.
   always_comb begin
      dec          = raw;
      dec.illegal  = bad;
      dec.rd_write = raw.rd_write && !bad && (instr[11:7] != 5'd0);
      if (bad) begin
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.muldiv    = 1'b0;
         dec.jalr      = 1'b0;
         dec.branch_op = BR_NEVER;
      end else begin
         dec.branch_op = raw.branch_op;
      end
      dec.rs1 = dec.rs1_read ? instr[19:15] : 5'd0;
      dec.rs2 = dec.rs2_read ? instr[24:20] : 5'd0;
      dec.rd  = dec.rd_write ? instr[11:7]  : 5'd0;
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage between fetch and execute.
//   clk, reset : clock and synchronous active-high reset
//   bus        : decode_if.slave -- fetch handshake (in_*), flush_in, and the
//                registered control bundle towards execute (out_*)
// One bundle register with valid/ready on both sides, a one-bubble load-use
// interlock, and a flush that kills both the held and the incoming instruction.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN     = DEFAULT_XLEN,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic    clk,
   input  logic    reset,
   decode_if.slave bus
);
   decode_bundle_t  dec;
   decode_bundle_t  held;
   logic [XLEN-1:0] held_pc;
   logic            valid;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            hazard;
   logic            ready;
   logic            accept;

   decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
      .instr (bus.in_instr),
      .dec   (dec)
   );

   // Load-use interlock and input handshake; held.rd is already 0 for
   // non-writing bundles, so the rd != 0 term also covers stores/branches.
   always_comb begin
      rs1_hit = dec.rs1_read && (dec.rs1 == held.rd);
      rs2_hit = dec.rs2_read && (dec.rs2 == held.rd);
      hazard  = valid && held.mem_read && (held.rd != 5'd0) && (rs1_hit || rs2_hit);
      ready   = (!valid || bus.out_ready) && !hazard && !bus.flush_in;
      accept  = bus.in_valid && ready;
   end

   // Output register: flush beats accept, accept beats drain, else hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= 1'b0;
         held    <= '0;
         held_pc <= '0;
      end else if (bus.flush_in) begin
         valid <= 1'b0;
      end else if (accept) begin
         valid   <= 1'b1;
         held    <= dec;
         held_pc <= bus.in_pc;
      end else if (valid && bus.out_ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

   assign bus.in_ready      = ready;
   assign bus.out_valid     = valid;
   assign bus.out_pc        = held_pc;
   assign bus.out_rs1       = held.rs1;
   assign bus.out_rs2       = held.rs2;
   assign bus.out_rd        = held.rd;
   assign bus.out_rs1_read  = held.rs1_read;
   assign bus.out_rs2_read  = held.rs2_read;
   assign bus.out_rd_write  = held.rd_write;
   assign bus.out_imm       = held.imm;
   assign bus.out_alu_op    = held.alu_op;
   assign bus.out_funct3    = held.funct3;
   assign bus.out_sub_sra   = held.sub_sra;
   assign bus.out_src1      = held.src1;
   assign bus.out_src2      = held.src2;
   assign bus.out_mem_read  = held.mem_read;
   assign bus.out_mem_write = held.mem_write;
   assign bus.out_mem_width = held.mem_width;
   assign bus.out_mem_zext  = held.mem_zext;
   assign bus.out_branch_op = held.branch_op;
   assign bus.out_jalr      = held.jalr;
   assign bus.out_muldiv    = held.muldiv;
   assign bus.out_illegal   = held.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed bundles. Each accepted
// instruction pushes its expected bundle; a monitor pops and compares on every
// output transfer. A second instance with ENABLE_M=0 sees the same inputs.
module tb_decode_stage;
   import decode_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   decode_if #(.XLEN(32)) bus ();
   decode_if #(.XLEN(32)) bus0 ();

   decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(bus));
   decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u_dut_nom (.clk(clk), .reset(reset), .bus(bus0));

   assign bus0.in_valid  = bus.in_valid;
   assign bus0.in_instr  = bus.in_instr;
   assign bus0.in_pc     = bus.in_pc;
   assign bus0.flush_in  = bus.flush_in;
   assign bus0.out_ready = bus.out_ready;

   typedef struct packed {
      logic [31:0]    pc;
      decode_bundle_t b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic decode_bundle_t sample_out();
      decode_bundle_t s;
      s.rs1 = bus.out_rs1;             s.rs2 = bus.out_rs2;           s.rd = bus.out_rd;
      s.rs1_read = bus.out_rs1_read;   s.rs2_read = bus.out_rs2_read; s.rd_write = bus.out_rd_write;
      s.imm = bus.out_imm;             s.alu_op = bus.out_alu_op;     s.funct3 = bus.out_funct3;
      s.sub_sra = bus.out_sub_sra;     s.src1 = bus.out_src1;         s.src2 = bus.out_src2;
      s.mem_read = bus.out_mem_read;   s.mem_write = bus.out_mem_write;
      s.mem_width = bus.out_mem_width; s.mem_zext = bus.out_mem_zext;
      s.branch_op = bus.out_branch_op; s.jalr = bus.out_jalr;
      s.muldiv = bus.out_muldiv;       s.illegal = bus.out_illegal;
      return s;
   endfunction

   function automatic decode_bundle_t base(input logic [6:0] cls, input logic [2:0] f3);
      decode_bundle_t b;
      b        = '0;
      b.alu_op = cls;
      b.funct3 = f3;
      return b;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Present one instruction until accepted; reports stall cycles and the
   // out_valid seen in the accepting cycle.
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bit push,
                       input decode_bundle_t e, output int stalls, output logic vld);
      bit   done;
      exp_t x;
      done   = 1'b0;
      stalls = 0;
      vld    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      bus.in_pc    = pc;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1'b1;
            vld  = bus.out_valid;
         end else begin
            stalls++;
         end
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: instr %h never accepted", instr);
      end else if (push) begin
         x.pc = pc;
         x.b  = e;
         exp_q.push_back(x);
      end
   endtask

   // Scoreboard monitor: one comparison per execute-side transfer.
   initial begin
      exp_t           x;
      decode_bundle_t got;
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready && !bus.flush_in) begin
            checks++;
            got = sample_out();
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: pc %h bundle %h, expected none", bus.out_pc, got);
            end else begin
               x = exp_q.pop_front();
               if (got !== x.b || bus.out_pc !== x.pc) begin
                  errors++;
                  $display("FAIL bundle pc %h: got pc %h bundle %h expected %h", x.pc, bus.out_pc, got, x.b);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      decode_bundle_t e;
      decode_bundle_t e_addi;
      decode_bundle_t snap;
      logic [31:0]    snap_pc;
      int             st;
      logic           v;

      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.flush_in  = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("reset_fields", 128'(sample_out()), 128'(0));
      check("reset_pc", 128'(bus.out_pc), 128'(0));
      check("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
      @(posedge clk);
      #1;

      // ADDI x1, x0, 5
      e = base(CLS_I_OP, 3'd0); e.rs1_read = 1'b1; e.rd = 5'd1; e.rd_write = 1'b1;
      e.imm = 32'd5; e.src2 = SRC2_IMM;
      e_addi = e;
      send(32'h00500093, 32'h100, 1'b1, e, st, v);
      check("addi_stalls", 128'(st), 128'(0));
      // LW x2, 0(x1)
      e = base(CLS_I_LD, 3'd2); e.rs1 = 5'd1; e.rs1_read = 1'b1; e.rd = 5'd2; e.rd_write = 1'b1;
      e.src2 = SRC2_IMM; e.mem_read = 1'b1; e.mem_width = MEM_WORD;
      send(32'h0000A103, 32'h104, 1'b1, e, st, v);
      // ADD x3, x2, x1 -- load-use on x2
      e = base(CLS_R, 3'd0); e.rs1 = 5'd2; e.rs2 = 5'd1; e.rs1_read = 1'b1; e.rs2_read = 1'b1;
      e.rd = 5'd3; e.rd_write = 1'b1;
      send(32'h001101B3, 32'h108, 1'b1, e, st, v);
      check("load_use_stalls", 128'(st), 128'(1));
      check("bubble_out_valid", 128'(v), 128'(1'b0));
      // MUL x3, x1, x2
      e = base(CLS_R, 3'd0); e.rs1 = 5'd1; e.rs2 = 5'd2; e.rs1_read = 1'b1; e.rs2_read = 1'b1;
      e.rd = 5'd3; e.rd_write = 1'b1; e.muldiv = 1'b1;
      send(32'h022081B3, 32'h10C, 1'b1, e, st, v);
      check("mul_stalls", 128'(st), 128'(0));
      @(negedge clk);
      check("nom_mul_valid", 128'(bus0.out_valid), 128'(1'b1));
      check("nom_mul_illegal", 128'(bus0.out_illegal), 128'(1'b1));
      check("nom_mul_rd_write", 128'(bus0.out_rd_write), 128'(1'b0));
      check("nom_mul_muldiv", 128'(bus0.out_muldiv), 128'(1'b0));
      @(posedge clk);
      #1;
      // BEQ x1, x2, +8
      e = base(CLS_B, 3'd0); e.rs1 = 5'd1; e.rs2 = 5'd2; e.rs1_read = 1'b1; e.rs2_read = 1'b1;
      e.imm = 32'd8; e.sub_sra = 1'b1; e.branch_op = BR_ZERO;
      send(32'h00208463, 32'h110, 1'b1, e, st, v);
      // JAL x1, +16
      e = base(CLS_J, 3'd0); e.rd = 5'd1; e.rd_write = 1'b1; e.imm = 32'd16;
      e.src1 = SRC1_PC; e.src2 = SRC2_FOUR; e.branch_op = BR_ALWAYS;
      send(32'h010000EF, 32'h114, 1'b1, e, st, v);
      check("jal_stalls", 128'(st), 128'(0));
      // SRAI x5, x6, 3
      e = base(CLS_I_OP, 3'd5); e.rs1 = 5'd6; e.rs1_read = 1'b1; e.rd = 5'd5; e.rd_write = 1'b1;
      e.imm = 32'h00000403; e.sub_sra = 1'b1; e.src2 = SRC2_IMM;
      send(32'h40335293, 32'h118, 1'b1, e, st, v);
      // SW x2, -4(x1)
      e = base(CLS_S, 3'd2); e.rs1 = 5'd1; e.rs2 = 5'd2; e.rs1_read = 1'b1; e.rs2_read = 1'b1;
      e.imm = 32'hFFFFFFFC; e.src2 = SRC2_IMM; e.mem_write = 1'b1; e.mem_width = MEM_WORD;
      send(32'hFE20AE23, 32'h11C, 1'b1, e, st, v);
      // LBU x7, 1(x0)
      e = base(CLS_I_LD, 3'd4); e.rs1_read = 1'b1; e.rd = 5'd7; e.rd_write = 1'b1; e.imm = 32'd1;
      e.src2 = SRC2_IMM; e.mem_read = 1'b1; e.mem_width = MEM_BYTE; e.mem_zext = 1'b1;
      send(32'h00104383, 32'h120, 1'b1, e, st, v);
      // Unknown opcode: reads nothing, so no interlock behind the load.
      e = base(CLS_NONE, 3'd7); e.illegal = 1'b1;
      send(32'hFFFFFFFF, 32'h124, 1'b1, e, st, v);
      check("illegal_stalls", 128'(st), 128'(0));
      // ADD x0, x1, x2 -- write to x0 suppressed
      e = base(CLS_R, 3'd0); e.rs1 = 5'd1; e.rs2 = 5'd2; e.rs1_read = 1'b1; e.rs2_read = 1'b1;
      send(32'h00208033, 32'h128, 1'b1, e, st, v);
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure, then flush with an otherwise acceptable incoming instruction.
      bus.out_ready = 1'b0;
      send(32'h00500093, 32'h200, 1'b0, e_addi, st, v);
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h001101B3;
      bus.in_pc    = 32'h204;
      @(negedge clk);
      snap    = sample_out();
      snap_pc = bus.out_pc;
      check("bp_out_valid", 128'(bus.out_valid), 128'(1'b1));
      check("bp_content", 128'(snap), 128'(e_addi));
      check("bp_pc", 128'(snap_pc), 128'(32'h200));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready", 128'(bus.in_ready), 128'(1'b0));
         check("bp_stable", 128'(sample_out()), 128'(snap));
         check("bp_valid_held", 128'(bus.out_valid), 128'(1'b1));
      end
      @(posedge clk);
      #1 bus.flush_in = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 128'(bus.in_ready), 128'(1'b0));
      @(posedge clk);
      #1 bus.flush_in = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_clears", 128'(bus.out_valid), 128'(1'b0));
      @(negedge clk);
      check("flush_drops_incoming", 128'(bus.out_valid), 128'(1'b0));
      @(posedge clk);
      #1;

      // Reset while stalled discards the held bundle.
      bus.out_ready = 1'b0;
      send(32'h00500093, 32'h300, 1'b0, e_addi, st, v);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("stall_reset_valid", 128'(bus.out_valid), 128'(1'b0));
      check("stall_reset_fields", 128'(sample_out()), 128'(0));
      check("stall_reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
      repeat (2) @(posedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage that sits between fetch and execute. It turns the fetched instruction into a complete control bundle: register indices, a sign-extended immediate, ALU/memory/branch controls and an illegal-instruction flag. A valid/ready handshake connects it to both neighbours. It interlocks one bubble on load-use hazards, supports pipeline flush, and can optionally decode the M extension.

## Interface
- XLEN, 32, datapath/immediate width (32 only for RV32I; parameter kept for package reuse)
- ENABLE_M, 0, 1 = decode MUL/DIV group, 0 = treat it as illegal
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents instruction
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- in_ready  out  1  decode accepts this cycle
- flush_in  in  1  kill the held output and the incoming instruction
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  registered pc
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 when not used)
- out_rs1_read, out_rs2_read, out_rd_write  out  1 each  register usage
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J formats)
- out_alu_op  out  7  opcode class (R, I_op, I_ld, S, B, U, J)
- out_funct3  out  3  funct3 passthrough
- out_sub_sra  out  1  SUB / SRA / SRAI select
- out_src1  out  4  0000 reg, 0101 pc, 1010 zero
- out_src2  out  4  0000 reg, 0101 imm, 1010 constant 4
- out_mem_read, out_mem_write  out  1 each  memory access
- out_mem_width  out  4  0000 word, 0101 half, 1010 byte
- out_mem_zext  out  1  LBU/LHU zero-extend
- out_branch_op  out  4  0000 never, 0101 zero, 1010 non-zero, 1111 always
- out_jalr  out  1  target is rs1+imm
- out_muldiv  out  1  M-extension operation
- out_illegal  out  1  unrecognised encoding

## Operation
- Output register update rule:
  - On in_valid && in_ready, the decoded bundle is loaded into the output register and out_valid is set to 1.
  - On out_valid && out_ready with no new load, out_valid is cleared to 0.
- in_ready = (!out_valid || out_ready) && !hazard && !flush_in.
- Load-use hazard: the held bundle is a valid load with rd≠0, and the incoming instruction reads that rd via rs1 or rs2 (only where rs1_read/rs2_read is set). In that case in_ready=0. If out_ready=1, out_valid drops to 0, which is exactly one bubble; the instruction is accepted on the next cycle.
- Flush: flush_in=1 clears out_valid on the next edge and drops the incoming instruction. Flush has priority over accept, hazard and hold.
- Illegal encodings cover an unknown opcode, a bad funct3/funct7, and the M group when ENABLE_M=0. For these: out_illegal=1, with rd_write, mem_read, mem_write and muldiv forced to 0 and branch_op=0000. The bundle is still passed downstream as valid.
- rd=x0 always forces out_rd_write=0.
- Branches: BEQ/BGE/BGEU use branch_op 0101; BNE/BLT/BLTU use 1010. All branches set sub_sra=1.
- JAL and JALR: src1=pc, src2=4, branch_op=1111. JALR also sets out_jalr=1.
- Stores: rd_write=0; out_rd=0.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 instruction per cycle when there is no hazard.
- While out_valid=1 and out_ready=0, every output holds stable.
- Reset: out_valid=0 and all out_* fields=0. in_ready=1 in the first cycle after reset.
- Simultaneous out handshake and in accept: the register reloads and out_valid stays 1.
- A hazard and a flush in the same cycle resolve as flush (the output is cleared).
- Reset asserted mid-stall discards the held bundle.

## Structure
- Package decode_pkg holds:
  - opcode class constants
  - branch-op, mem-width and src encodings
  - M funct7 constant
  - packed struct decode_bundle_t
- Sub-module decode_comb: a purely combinational instr → decode_bundle_t decoder, parametrised by ENABLE_M.
- decode_stage itself holds the register, handshake and hazard logic.

## Test plan
- Reset: hold reset 3 cycles → out_valid=0, all fields 0, in_ready=1.
- ADDI 0x00500093 at pc 0x100 → next cycle out_valid=1, rd=1, rs1=0, imm=5, src2=0101, rd_write=1.
- LW 0x0000A103 followed by ADD 0x001101B3, out_ready=1 → exactly one bubble cycle (out_valid=0), then ADD appears with rs1=2, rs2=1.
- MUL 0x022081B3 → with ENABLE_M=1: muldiv=1, rd=3. With ENABLE_M=0: illegal=1, rd_write=0.
- BEQ 0x00208463 → imm=8, branch_op=0101, sub_sra=1. JAL 0x010000EF → imm=16, branch_op=1111, src2=1010.
- Back-pressure: hold out_ready=0 for 4 cycles → outputs stable and in_ready=0. Assert flush_in → out_valid=0 next cycle.
